// File: rtl/rx_delay_calib_pkg.sv
// Shared types and sizes for the receiver delay-calibration scanner.
package rx_delay_calib_pkg;

  localparam int unsigned NUM_TAPS = 32;
  localparam int unsigned TAP_W    = 5;
  localparam int unsigned LEN_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DWELL,
    S_EVAL,
    S_NEXT,
    S_APPLY,
    S_FINISH
  } calib_state_t;

endpackage

// File: rtl/rx_calib_run_tracker.sv
// Tracks the current passing run of taps and keeps the longest run seen so far.
module rx_calib_run_tracker
  import rx_delay_calib_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             eval_i,
  input  logic             pass_i,
  input  logic             last_i,
  input  logic [TAP_W-1:0] tap_i,
  input  logic             edge_i,
  output logic [LEN_W-1:0] best_len_o,
  output logic [TAP_W-1:0] best_start_o,
  output logic             best_edge_o
);

  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [TAP_W-1:0] cur_start_q, cur_start_d;
  logic [LEN_W-1:0] best_len_q, best_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic             best_edge_q, best_edge_d;
  logic [LEN_W-1:0] run_len;
  logic [TAP_W-1:0] run_start;
  logic             close_run;

  // Extend the run on a pass; close it on a fail or at the last tap of an edge.
  always_comb begin
    run_len      = cur_len_q;
    run_start    = cur_start_q;
    close_run    = !pass_i || last_i;
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    best_edge_d  = best_edge_q;
    if (pass_i) begin
      run_len = cur_len_q + LEN_W'(1);
      if (cur_len_q == '0) run_start = tap_i;
    end
    if (clear_i) begin
      cur_len_d    = '0;
      cur_start_d  = '0;
      best_len_d   = '0;
      best_start_d = '0;
      best_edge_d  = 1'b0;
    end else if (eval_i) begin
      cur_start_d = run_start;
      cur_len_d   = close_run ? '0 : run_len;
      // Strict compare keeps the earlier window on a tie.
      if (close_run && (run_len > best_len_q)) begin
        best_len_d   = run_len;
        best_start_d = run_start;
        best_edge_d  = edge_i;
      end
    end
  end

  // Run registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      best_edge_q  <= 1'b0;
    end else begin
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      best_edge_q  <= best_edge_d;
    end
  end

  assign best_len_o   = best_len_q;
  assign best_start_o = best_start_q;
  assign best_edge_o  = best_edge_q;

endmodule

// File: rtl/rx_delay_calib.sv
// Scans every delay tap on both DDR edges, finds the widest error-free window
// and loads its centre into the receiver delay line.
module rx_delay_calib
  import rx_delay_calib_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned DWELL_CYCLES  = 4096,
  parameter int unsigned MIN_WINDOW    = 3
) (
  input  logic       BUS_CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       RX_READY,
  input  logic [7:0] DECODER_ERR_CNT,
  output logic [4:0] DLY_VALUE,
  output logic       DLY_LOAD,
  output logic       SAMPLING_EDGE,
  output logic       ERR_RESET,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [4:0] BEST_TAP,
  output logic       BEST_EDGE,
  output logic [5:0] WINDOW_LEN
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  calib_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TAP_W-1:0] tap_q;
  logic             edge_q;
  logic             pass_q;
  logic [TAP_W-1:0] dly_value_q;
  logic             dly_load_q;
  logic             sampling_edge_q;
  logic             err_reset_q;
  logic             busy_q;
  logic             done_q;
  logic             fail_q;
  logic [TAP_W-1:0] best_tap_q;
  logic             best_edge_q;
  logic [LEN_W-1:0] window_len_q;

  logic             start_ok;
  logic             last_tap;
  logic             point_pass;
  logic [LEN_W-1:0] trk_len;
  logic [TAP_W-1:0] trk_start;
  logic             trk_edge;
  logic             win_ok;
  logic [TAP_W-1:0] win_center;

  // Decode scan events and the window centre.
  always_comb begin
    start_ok   = (state_q == S_IDLE) && START && !ABORT;
    last_tap   = (tap_q == TAP_W'(NUM_TAPS - 1));
    point_pass = pass_q && (DECODER_ERR_CNT == 8'd0);
    win_ok     = (trk_len >= LEN_W'(MIN_WINDOW)) && (trk_len != '0);
    win_center = trk_start + TAP_W'((trk_len - LEN_W'(1)) >> 1);
  end

  rx_calib_run_tracker u_tracker (
    .clk_i        (BUS_CLK),
    .rst_i        (RST),
    .clear_i      (start_ok),
    .eval_i       ((state_q == S_EVAL) && !ABORT),
    .pass_i       (point_pass),
    .last_i       (last_tap),
    .tap_i        (tap_q),
    .edge_i       (edge_q),
    .best_len_o   (trk_len),
    .best_start_o (trk_start),
    .best_edge_o  (trk_edge)
  );

  // Scan FSM, counters and registered outputs.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      tap_q           <= '0;
      edge_q          <= 1'b0;
      pass_q          <= 1'b0;
      dly_value_q     <= '0;
      dly_load_q      <= 1'b0;
      sampling_edge_q <= 1'b0;
      err_reset_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fail_q          <= 1'b0;
      best_tap_q      <= '0;
      best_edge_q     <= 1'b0;
      window_len_q    <= '0;
    end else if (ABORT && (state_q != S_IDLE)) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dly_load_q  <= 1'b0;
      err_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dly_load_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q         <= S_LOAD;
            tap_q           <= '0;
            edge_q          <= 1'b0;
            busy_q          <= 1'b1;
            fail_q          <= 1'b0;
            dly_value_q     <= '0;
            sampling_edge_q <= 1'b0;
            dly_load_q      <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q     <= S_SETTLE;
          err_reset_q <= 1'b1;
          cnt_q       <= '0;
        end
        S_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_q     <= S_DWELL;
            err_reset_q <= 1'b0;
            cnt_q       <= '0;
            pass_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DWELL: begin
          if (!RX_READY) pass_q <= 1'b0;
          if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            state_q <= S_EVAL;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_EVAL: state_q <= S_NEXT;
        S_NEXT: begin
          if (!last_tap) begin
            state_q     <= S_LOAD;
            tap_q       <= tap_q + TAP_W'(1);
            dly_value_q <= tap_q + TAP_W'(1);
            dly_load_q  <= 1'b1;
          end else if (!edge_q) begin
            state_q         <= S_LOAD;
            tap_q           <= '0;
            edge_q          <= 1'b1;
            dly_value_q     <= '0;
            sampling_edge_q <= 1'b1;
            dly_load_q      <= 1'b1;
          end else begin
            state_q         <= S_APPLY;
            window_len_q    <= trk_len;
            fail_q          <= !win_ok;
            best_tap_q      <= win_ok ? win_center : '0;
            best_edge_q     <= win_ok ? trk_edge : 1'b0;
            dly_value_q     <= win_ok ? win_center : '0;
            sampling_edge_q <= win_ok ? trk_edge : 1'b0;
            dly_load_q      <= 1'b1;
          end
        end
        S_APPLY: begin
          state_q <= S_FINISH;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign DLY_VALUE     = dly_value_q;
  assign DLY_LOAD      = dly_load_q;
  assign SAMPLING_EDGE = sampling_edge_q;
  assign ERR_RESET     = err_reset_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign FAIL          = fail_q;
  assign BEST_TAP      = best_tap_q;
  assign BEST_EDGE     = best_edge_q;
  assign WINDOW_LEN    = window_len_q;

endmodule

// File: tb/tb_rx_delay_calib.sv
// Directed bench for rx_delay_calib with a tap-mask receiver model.
module tb_rx_delay_calib;

  logic       BUS_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       RX_READY;
  logic [7:0] DECODER_ERR_CNT;
  logic [4:0] DLY_VALUE;
  logic       DLY_LOAD;
  logic       SAMPLING_EDGE;
  logic       ERR_RESET;
  logic       BUSY;
  logic       DONE;
  logic       FAIL;
  logic [4:0] BEST_TAP;
  logic       BEST_EDGE;
  logic [5:0] WINDOW_LEN;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mask0 = '0;
  logic [31:0] mask1 = '0;
  int          err_tap = -1;
  bit          glitch = 1'b0;

  int   obs_cycles, obs_loads, obs_er_points, obs_er_bad;
  bit   obs_timeout;
  logic [4:0] obs_last_load;
  logic       obs_last_edge;

  rx_delay_calib #(.SETTLE_CYCLES(4), .DWELL_CYCLES(16), .MIN_WINDOW(3)) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .RX_READY(RX_READY), .DECODER_ERR_CNT(DECODER_ERR_CNT),
    .DLY_VALUE(DLY_VALUE), .DLY_LOAD(DLY_LOAD), .SAMPLING_EDGE(SAMPLING_EDGE),
    .ERR_RESET(ERR_RESET), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
    .BEST_TAP(BEST_TAP), .BEST_EDGE(BEST_EDGE), .WINDOW_LEN(WINDOW_LEN)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // Receiver model: a point is good when its mask bit is set.
  always_comb begin
    logic ok;
    ok = SAMPLING_EDGE ? mask1[DLY_VALUE] : mask0[DLY_VALUE];
    RX_READY = ok && !glitch;
    DECODER_ERR_CNT = ok ? 8'd0 : 8'd7;
    if ((err_tap == int'(DLY_VALUE)) && !SAMPLING_EDGE && !ERR_RESET) DECODER_ERR_CNT = 8'd1;
  end

  // Runs one full scan from a negedge; stops with DONE high at a negedge.
  task automatic run_scan(input logic [31:0] m0, input logic [31:0] m1,
                          input int g_tap, input int e_tap, input int rs_tap);
    bit er_prev = 1'b0;
    int er_run = 0;
    bit rs_done = 1'b0;
    mask0 = m0; mask1 = m1; err_tap = e_tap;
    obs_cycles = 0; obs_loads = 0; obs_er_points = 0; obs_er_bad = 0; obs_timeout = 1'b0;
    obs_last_load = '0; obs_last_edge = 1'b0;
    START = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0;
    obs_cycles = 1;
    while (DONE !== 1'b1) begin
      if (obs_cycles > 4000) begin obs_timeout = 1'b1; break; end
      if (DLY_LOAD === 1'b1) begin
        obs_loads++; obs_last_load = DLY_VALUE; obs_last_edge = SAMPLING_EDGE;
      end
      if (ERR_RESET === 1'b1) er_run++;
      else if (er_prev) begin
        obs_er_points++;
        if (er_run != 4) obs_er_bad++;
        er_run = 0;
      end
      glitch = !ERR_RESET && er_prev && (int'(DLY_VALUE) == g_tap) && !SAMPLING_EDGE;
      er_prev = ERR_RESET;
      if (!rs_done && ERR_RESET && (int'(DLY_VALUE) == rs_tap)) begin
        START = 1'b1; rs_done = 1'b1;
      end else START = 1'b0;
      @(negedge BUS_CLK);
      obs_cycles++;
    end
    START = 1'b0; glitch = 1'b0; err_tap = -1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge BUS_CLK);
    n_checks++; if ({DLY_VALUE, DLY_LOAD, SAMPLING_EDGE, ERR_RESET} !== 8'd0) begin n_fail++; $display("FAIL reset_dly: got %h want 0", {DLY_VALUE, DLY_LOAD, SAMPLING_EDGE, ERR_RESET}); end
    n_checks++; if ({BUSY, DONE, FAIL} !== 3'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {BUSY, DONE, FAIL}); end
    n_checks++; if ({BEST_TAP, BEST_EDGE, WINDOW_LEN} !== 12'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", {BEST_TAP, BEST_EDGE, WINDOW_LEN}); end
    RST = 1'b0;
    @(negedge BUS_CLK);
  endtask

  task automatic test_single_window();
    run_scan(32'h0003_FC00, 32'h0, -1, -1, -1);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL single_timeout: got no DONE within 4000 cycles"); end
    n_checks++; if (BEST_TAP !== 5'd13) begin n_fail++; $display("FAIL single_best_tap: got %0d want 13", BEST_TAP); end
    n_checks++; if (BEST_EDGE !== 1'b0) begin n_fail++; $display("FAIL single_best_edge: got %0d want 0", BEST_EDGE); end
    n_checks++; if (WINDOW_LEN !== 6'd8) begin n_fail++; $display("FAIL single_window_len: got %0d want 8", WINDOW_LEN); end
    n_checks++; if (FAIL !== 1'b0) begin n_fail++; $display("FAIL single_fail_flag: got %0d want 0", FAIL); end
    n_checks++; if (DLY_VALUE !== 5'd13 || SAMPLING_EDGE !== 1'b0) begin n_fail++; $display("FAIL single_dly_value: got %0d/%0d want 13/0", DLY_VALUE, SAMPLING_EDGE); end
    n_checks++; if (obs_loads != 65 || obs_last_load !== 5'd13) begin n_fail++; $display("FAIL single_loads: got %0d loads last %0d want 65 last 13", obs_loads, obs_last_load); end
    n_checks++; if (obs_cycles < 1474 || obs_cycles > 1476) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 1475+-1", obs_cycles); end
    n_checks++; if (obs_er_points != 64 || obs_er_bad != 0) begin n_fail++; $display("FAIL single_err_reset: got %0d points %0d bad want 64 points 0 bad", obs_er_points, obs_er_bad); end
    @(negedge BUS_CLK);
    n_checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got DONE=%0d BUSY=%0d want 0 0", DONE, BUSY); end
  endtask

  task automatic test_edge1_wins();
    run_scan(32'h0000_01E0, 32'h07F0_0000, -1, -1, -1);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL edge1_timeout: got no DONE"); end
    n_checks++; if ({BEST_EDGE, BEST_TAP, WINDOW_LEN} !== {1'b1, 5'd23, 6'd7}) begin n_fail++; $display("FAIL edge1_result: got edge %0d tap %0d len %0d want 1 23 7", BEST_EDGE, BEST_TAP, WINDOW_LEN); end
    n_checks++; if (DLY_VALUE !== 5'd23 || SAMPLING_EDGE !== 1'b1 || obs_last_edge !== 1'b1) begin n_fail++; $display("FAIL edge1_dly: got %0d/%0d want 23/1", DLY_VALUE, SAMPLING_EDGE); end
    @(negedge BUS_CLK);
  endtask

  task automatic test_tie();
    run_scan(32'h0000_00F0, 32'h0000_F000, -1, -1, -1);
    n_checks++; if ({BEST_EDGE, BEST_TAP, WINDOW_LEN, FAIL} !== {1'b0, 5'd5, 6'd4, 1'b0}) begin n_fail++; $display("FAIL tie_result: got edge %0d tap %0d len %0d fail %0d want 0 5 4 0", BEST_EDGE, BEST_TAP, WINDOW_LEN, FAIL); end
    @(negedge BUS_CLK);
  endtask

  task automatic test_narrow_fail();
    run_scan(32'hC000_0000, 32'h0, -1, -1, -1);
    n_checks++; if (FAIL !== 1'b1) begin n_fail++; $display("FAIL narrow_fail_flag: got %0d want 1", FAIL); end
    n_checks++; if (WINDOW_LEN !== 6'd2) begin n_fail++; $display("FAIL narrow_window_len: got %0d want 2", WINDOW_LEN); end
    n_checks++; if ({DLY_VALUE, SAMPLING_EDGE, BEST_TAP, BEST_EDGE} !== 12'd0) begin n_fail++; $display("FAIL narrow_dly: got dly %0d edge %0d best %0d/%0d want all 0", DLY_VALUE, SAMPLING_EDGE, BEST_TAP, BEST_EDGE); end
    @(negedge BUS_CLK);
  endtask

  task automatic test_all_pass();
    run_scan(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    n_checks++; if ({BEST_EDGE, BEST_TAP, WINDOW_LEN, FAIL} !== {1'b0, 5'd15, 6'd32, 1'b0}) begin n_fail++; $display("FAIL all_pass_result: got edge %0d tap %0d len %0d fail %0d want 0 15 32 0", BEST_EDGE, BEST_TAP, WINDOW_LEN, FAIL); end
    @(negedge BUS_CLK);
  endtask

  task automatic test_abort();
    int guard = 0;
    bit bad = 1'b0;
    START = 1'b1; ABORT = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0; ABORT = 1'b0;
    n_checks++; if (BUSY !== 1'b0 || DLY_LOAD !== 1'b0) begin n_fail++; $display("FAIL abort_start_same_cycle: got BUSY=%0d LOAD=%0d want 0 0", BUSY, DLY_LOAD); end
    mask0 = '1; mask1 = '1;
    START = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0;
    while (!(ERR_RESET === 1'b1 && DLY_VALUE === 5'd9) && guard < 1000) begin @(negedge BUS_CLK); guard++; end
    while (ERR_RESET === 1'b1 && guard < 1000) begin @(negedge BUS_CLK); guard++; end
    n_checks++; if (guard >= 1000) begin n_fail++; $display("FAIL abort_reach_tap9: got timeout want dwell at tap 9"); end
    repeat (3) @(negedge BUS_CLK);
    ABORT = 1'b1;
    @(negedge BUS_CLK);
    ABORT = 1'b0;
    n_checks++; if (BUSY !== 1'b0 || ERR_RESET !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got BUSY=%0d ERR_RESET=%0d want 0 0", BUSY, ERR_RESET); end
    n_checks++; if (DLY_VALUE !== 5'd9) begin n_fail++; $display("FAIL abort_hold_dly: got %0d want 9", DLY_VALUE); end
    for (int i = 0; i < 100; i++) begin
      if (DONE !== 1'b0 || BUSY !== 1'b0 || DLY_LOAD !== 1'b0) bad = 1'b1;
      @(negedge BUS_CLK);
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL abort_stays_idle: got activity after abort want none"); end
    n_checks++; if ({BEST_TAP, WINDOW_LEN, FAIL} !== {5'd15, 6'd32, 1'b0}) begin n_fail++; $display("FAIL abort_results_kept: got tap %0d len %0d fail %0d want 15 32 0", BEST_TAP, WINDOW_LEN, FAIL); end
  endtask

  task automatic test_rst_mid_settle();
    int guard = 0;
    START = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0;
    while (ERR_RESET !== 1'b1 && guard < 100) begin @(negedge BUS_CLK); guard++; end
    @(negedge BUS_CLK);
    RST = 1'b1;
    @(negedge BUS_CLK);
    n_checks++; if ({DLY_VALUE, DLY_LOAD, SAMPLING_EDGE, ERR_RESET, BUSY, DONE, FAIL} !== 11'd0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %h want 0", {DLY_VALUE, DLY_LOAD, SAMPLING_EDGE, ERR_RESET, BUSY, DONE, FAIL}); end
    n_checks++; if ({BEST_TAP, BEST_EDGE, WINDOW_LEN} !== 12'd0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", {BEST_TAP, BEST_EDGE, WINDOW_LEN}); end
    RST = 1'b0;
    @(negedge BUS_CLK);
  endtask

  task automatic test_rdy_glitch();
    run_scan(32'h0003_FC00, 32'h0, 12, -1, -1);
    n_checks++; if ({BEST_EDGE, BEST_TAP, WINDOW_LEN} !== {1'b0, 5'd15, 6'd5}) begin n_fail++; $display("FAIL rdy_glitch_result: got edge %0d tap %0d len %0d want 0 15 5", BEST_EDGE, BEST_TAP, WINDOW_LEN); end
    @(negedge BUS_CLK);
  endtask

  task automatic test_err_cnt();
    run_scan(32'h0003_FC00, 32'h0, -1, 12, -1);
    n_checks++; if ({BEST_EDGE, BEST_TAP, WINDOW_LEN} !== {1'b0, 5'd15, 6'd5}) begin n_fail++; $display("FAIL err_cnt_result: got edge %0d tap %0d len %0d want 0 15 5", BEST_EDGE, BEST_TAP, WINDOW_LEN); end
    @(negedge BUS_CLK);
  endtask

  task automatic test_start_while_busy();
    run_scan(32'h0003_FC00, 32'h0, -1, -1, 3);
    n_checks++; if (obs_cycles < 1474 || obs_cycles > 1476) begin n_fail++; $display("FAIL busy_start_latency: got %0d cycles want 1475+-1", obs_cycles); end
    n_checks++; if (obs_loads != 65) begin n_fail++; $display("FAIL busy_start_loads: got %0d want 65", obs_loads); end
    n_checks++; if ({BEST_TAP, WINDOW_LEN} !== {5'd13, 6'd8}) begin n_fail++; $display("FAIL busy_start_result: got tap %0d len %0d want 13 8", BEST_TAP, WINDOW_LEN); end
    @(negedge BUS_CLK);
  endtask

  initial begin
    @(negedge BUS_CLK);
    test_reset();
    test_single_window();
    test_edge1_wins();
    test_tie();
    test_narrow_fail();
    test_all_pass();
    test_abort();
    test_rst_mid_settle();
    test_rdy_glitch();
    test_err_cnt();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
